// File: rtl/alu_issue_stage.sv
// Issue stage for the combinational 16-bit ALU: input FIFO with illegal-op filter,
// registered operand issue, and a valid/ready result register.
// Optional: define ALU_FLAGS_EN to add registered res_zero / res_neg outputs.
module alu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic [3:0]                 alu_op,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    input  logic [WIDTH-1:0]           alu_result,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_data,
    output logic                       illegal_pulse,
    output logic [7:0]                 err_count,
    output logic [$clog2(DEPTH):0]     fifo_level
`ifdef ALU_FLAGS_EN
    ,
    output logic                       res_zero,
    output logic                       res_neg
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, empty;
    logic          xfer, legal, push, pop;
    logic          iss_v, adv, cap;

    assign full     = (fifo_level == FULL_LVL);
    assign empty    = (fifo_level == '0);
    assign in_ready = !full && !flush;
    assign xfer     = in_valid && in_ready;
    assign legal    = (in_op[3:2] == 2'b00);
    assign push     = xfer && legal;
    assign head     = mem[rd_ptr];

    // Issue slot moves whenever its current op can leave (or it holds nothing).
    assign adv = !iss_v || !res_valid || res_ready;
    assign pop = adv && !empty && !flush;
    assign cap = iss_v && (!res_valid || res_ready);

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= '{op: in_op, a: in_a, b: in_b};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Operands hold their last values when the slot drains, only iss_v clears.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            iss_v  <= 1'b0;
            alu_op <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
        end else if (flush) begin
            iss_v  <= 1'b0;
        end else if (adv) begin
            if (!empty) begin
                iss_v  <= 1'b1;
                alu_op <= head.op;
                alu_a  <= head.a;
                alu_b  <= head.b;
            end else begin
                iss_v  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
`ifdef ALU_FLAGS_EN
            res_zero  <= 1'b0;
            res_neg   <= 1'b0;
`endif
        end else if (flush) begin
            res_valid <= 1'b0;
        end else if (cap) begin
            res_valid <= 1'b1;
            res_data  <= alu_result;
`ifdef ALU_FLAGS_EN
            res_zero  <= (alu_result == '0);
            res_neg   <= alu_result[WIDTH-1];
`endif
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            illegal_pulse <= 1'b0;
            err_count     <= '0;
        end else if (flush) begin
            illegal_pulse <= 1'b0;
        end else begin
            illegal_pulse <= xfer && !legal;
            if (xfer && !legal && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU closing the loop.
module tb_alu_issue_stage;
    localparam int DEPTH = 4;
    localparam int WIDTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_op = '0;
    logic [WIDTH-1:0] in_a = '0, in_b = '0;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_data;
    logic             illegal_pulse;
    logic [7:0]       err_count;
    logic [LW-1:0]    fifo_level;
`ifdef ALU_FLAGS_EN
    logic             res_zero, res_neg;
`endif

    alu_issue_stage #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .illegal_pulse(illegal_pulse), .err_count(err_count), .fifo_level(fifo_level)
`ifdef ALU_FLAGS_EN
        , .res_zero(res_zero), .res_neg(res_neg)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] alu_f(input logic [3:0] op, input logic [WIDTH-1:0] a, b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);

    int errors = 0;
    int checks = 0;
    int n_res  = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshakes are evaluated mid-cycle, where inputs and outputs are stable.
    always @(negedge clock) begin
        if (!reset_n || flush) begin
            exp_q.delete();
        end else begin
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", 32'(res_data), 32'hDEAD_BEEF);
                else begin
                    chk("sb_res", 32'(res_data), 32'(exp_q.pop_front()));
                    n_res++;
                end
            end
            if (in_valid && in_ready && in_op[3:2] == 2'b00)
                exp_q.push_back(alu_f(in_op, in_a, in_b));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] a, b);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic wait_res();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) chk("res_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int base;
        #2;
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_pulse", 32'(illegal_pulse), 0);
        @(posedge clock); #1;
        reset_n = 1'b1; res_ready = 1'b1;
        tick();

        // 1: single add, latency
        send(4'd0, 16'h0003, 16'h0004);
        in_valid = 1'b0;
        chk("t1_e0_valid", 32'(res_valid), 0);
        tick();
        chk("t1_alu_op", 32'(alu_op), 0);
        chk("t1_alu_a", 32'(alu_a), 32'h3);
        chk("t1_alu_b", 32'(alu_b), 32'h4);
        chk("t1_e1_valid", 32'(res_valid), 0);
        tick();
        chk("t1_e2_valid", 32'(res_valid), 1);
        chk("t1_data", 32'(res_data), 32'h7);
        tick();
        chk("t1_e3_valid", 32'(res_valid), 0);

        // 2: back-to-back sub/and/or
        send(4'd1, 16'h0010, 16'h0001);
        send(4'd2, 16'h00F0, 16'h0FF0);
        send(4'd3, 16'h0F00, 16'h00F0);
        in_valid = 1'b0;
        chk("t2_v0", 32'(res_valid), 1);
        chk("t2_d0", 32'(res_data), 32'h000F);
        tick();
        chk("t2_v1", 32'(res_valid), 1);
        chk("t2_d1", 32'(res_data), 32'h00F0);
        tick();
        chk("t2_v2", 32'(res_valid), 1);
        chk("t2_d2", 32'(res_data), 32'h0FF0);
        tick();
        chk("t2_v3", 32'(res_valid), 0);

        // 3: backpressure fills the FIFO
        res_ready = 1'b0;
        for (int k = 1; k <= 6; k++)
            send(4'(k % 4), 16'(16'h0100 * k + k), 16'(k));
        in_valid = 1'b0;
        tick(); tick();
        chk("t3_level", 32'(fifo_level), 4);
        chk("t3_in_ready", 32'(in_ready), 0);
        chk("t3_res_valid", 32'(res_valid), 1);
        base = n_res;
        res_ready = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
        chk("t3_drain", 32'(exp_q.size()), 0);
        chk("t3_count", 32'(n_res - base), 6);

        // 4: illegal filter and saturation
        send(4'h9, 16'h1111, 16'h2222);
        in_valid = 1'b0;
        chk("t4_pulse", 32'(illegal_pulse), 1);
        chk("t4_err1", 32'(err_count), 1);
        chk("t4_level", 32'(fifo_level), 0);
        tick();
        chk("t4_pulse_off", 32'(illegal_pulse), 0);
        tick();
        chk("t4_no_res", 32'(res_valid), 0);
        for (int i = 0; i < 300; i++)
            send(4'(4 + i % 12), 16'(i), 16'(i));
        in_valid = 1'b0;
        chk("t4_err_sat", 32'(err_count), 255);
        tick();

        // 5: flush with a loaded pipeline
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            send(4'd0, 16'(k), 16'h0100);
        in_valid = 1'b0;
        tick(); tick();
        chk("t5_level_pre", 32'(fifo_level), 3);
        chk("t5_valid_pre", 32'(res_valid), 1);
        flush = 1'b1;
        in_valid = 1'b1; in_op = 4'd0; in_a = 16'h7777; in_b = 16'h1;
        #1;
        chk("t5_in_ready_flush", 32'(in_ready), 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_level", 32'(fifo_level), 0);
        chk("t5_valid", 32'(res_valid), 0);
        chk("t5_err_kept", 32'(err_count), 255);
        tick();
        chk("t5_valid_after", 32'(res_valid), 0);
        res_ready = 1'b1;
        send(4'd0, 16'h1234, 16'h1111);
        in_valid = 1'b0;
        wait_res();
        chk("t5_new_op", 32'(res_data), 32'h2345);
        tick(); tick();

        // 6: asynchronous reset mid-stream
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            send(4'd3, 16'(16'h0010 << k), 16'h0001);
        in_valid = 1'b0;
        tick();
        #3 reset_n = 1'b0;
        #1;
        chk("t6_valid", 32'(res_valid), 0);
        chk("t6_data", 32'(res_data), 0);
        chk("t6_alu_a", 32'(alu_a), 0);
        chk("t6_alu_b", 32'(alu_b), 0);
        chk("t6_level", 32'(fifo_level), 0);
        chk("t6_err", 32'(err_count), 0);
        @(posedge clock); #1;
        reset_n = 1'b1; res_ready = 1'b1;
        tick();
        send(4'd1, 16'h0001, 16'h0002);
        in_valid = 1'b0;
        wait_res();
        chk("t6_sub", 32'(res_data), 32'hFFFF);
`ifdef ALU_FLAGS_EN
        chk("t6_neg", 32'(res_neg), 1);
        chk("t6_zero", 32'(res_zero), 0);
`endif
        tick();
        send(4'd0, 16'h0000, 16'h0000);
        in_valid = 1'b0;
        wait_res();
        chk("t6_zero_data", 32'(res_data), 0);
`ifdef ALU_FLAGS_EN
        chk("t6_zero_flag", 32'(res_zero), 1);
        chk("t6_neg_clr", 32'(res_neg), 0);
`endif
        tick(); tick();
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
